// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0004;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_queue.sv
// DEPTH-entry circular FIFO of fetched {pc, instr} pairs with synchronous flush.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push_do;
  logic           pop_do;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Guard against pushing into a full queue or popping an empty one.
  assign push_do = push & (count != CW'(DEPTH));
  assign pop_do  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_do) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_do)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_do, pop_do})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; the top masks it while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_do && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: PC, icache request tracking, issue control and decode-side queue.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] iaddr,
  input  logic [XLEN-1:0] instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_vld_q;
  logic [CW-1:0]   q_count;
  logic [CW:0]     occupancy;
  fetch_entry_t    q_head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            issue;

  // Handshake: an entry transfers on a rising edge where out_valid & out_ready are both high;
  // out_valid never drops and out_pc/out_instr never change while out_valid & ~out_ready,
  // except on redirect or reset, which flush the queue.
  assign pop = out_valid & out_ready;

  // Count the in-flight word as occupied so a push can never find the queue full.
  assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, req_vld_q};
  assign issue     = ~redirect_valid & ((occupancy < (CW + 1)'(DEPTH)) | pop);
  assign push      = req_vld_q & ~redirect_valid;

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      req_vld_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q      <= {redirect_pc[XLEN-1:2], 2'b00};
      req_vld_q <= 1'b0;
    end else if (issue) begin
      pc_q      <= pc_q + XLEN'(PC_STEP);
      req_pc_q  <= pc_q;
      req_vld_q <= 1'b1;
    end else begin
      req_vld_q <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (q_head),
    .count      (q_count)
  );

  assign iaddr     = pc_q;
  assign out_valid = (q_count != '0);
  assign out_instr = out_valid ? q_head.instr : '0;
  assign out_pc    = out_valid ? q_head.pc : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit against a one-cycle-latency icache model.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iaddr          (iaddr),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // icache model: address sampled at the edge, data valid for the following cycle
  always @(posedge clk) instr <= iaddr ^ 32'hA5A5_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) step();
    n_cmp++; if (iaddr !== 32'h4) begin n_bad++; $display("FAIL reset_iaddr: got %h want %h", iaddr, 32'h4); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_latency1: got valid %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h4 + 32'(4 * i));
    while (exp_q.size() != 0) begin
      exp_pc = exp_q.pop_front();
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid: got %b want 1 at pc %h", out_valid, exp_pc); end
      n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL stream_pc: got %h want %h", out_pc, exp_pc); end
      n_cmp++; if (out_instr !== (exp_pc ^ 32'hA5A5_0000)) begin n_bad++; $display("FAIL stream_instr: got %h want %h", out_instr, exp_pc ^ 32'hA5A5_0000); end
    end
    exp_pc = exp_pc + 32'h4;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    held = exp_pc - 32'h4;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== held) begin n_bad++; $display("FAIL hold_head: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, held); end
      n_cmp++; if (out_instr !== (held ^ 32'hA5A5_0000)) begin n_bad++; $display("FAIL hold_instr: got %h want %h", out_instr, held ^ 32'hA5A5_0000); end
      n_cmp++; if (iaddr !== held + 32'h8) begin n_bad++; $display("FAIL hold_iaddr: got %h want %h", iaddr, held + 32'h8); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin n_bad++; $display("FAIL release_pc: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, exp_pc); end
      n_cmp++; if (out_instr !== (exp_pc ^ 32'hA5A5_0000)) begin n_bad++; $display("FAIL release_instr: got %h want %h", out_instr, exp_pc ^ 32'hA5A5_0000); end
      exp_pc = exp_pc + 32'h4;
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0041;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got valid %b pc %h want 0", out_valid, out_pc); end
    n_cmp++; if (iaddr !== 32'h40) begin n_bad++; $display("FAIL redir_iaddr: got %h want %h", iaddr, 32'h40); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_stale: got valid %b pc %h want 0", out_valid, out_pc); end
    exp_pc = 32'h40;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin n_bad++; $display("FAIL redir_pc: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, exp_pc); end
      n_cmp++; if (out_instr !== (exp_pc ^ 32'hA5A5_0000)) begin n_bad++; $display("FAIL redir_instr: got %h want %h", out_instr, exp_pc ^ 32'hA5A5_0000); end
      exp_pc = exp_pc + 32'h4;
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] head_pc;
    head_pc   = exp_pc - 32'h4;
    out_ready = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== head_pc) begin n_bad++; $display("FAIL rpop_head: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, head_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rpop_younger: got valid %b pc %h want 0", out_valid, out_pc); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rpop_gap: got valid %b pc %h want 0", out_valid, out_pc); end
    exp_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin n_bad++; $display("FAIL rpop_pc: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, exp_pc); end
      exp_pc = exp_pc + 32'h4;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [3];
    seq[0] = 32'hFFFF_FFFC;
    seq[1] = 32'h0000_0000;
    seq[2] = 32'h0000_0004;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== seq[i]) begin n_bad++; $display("FAIL wrap_pc: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, seq[i]); end
      n_cmp++; if (out_instr !== (seq[i] ^ 32'hA5A5_0000)) begin n_bad++; $display("FAIL wrap_instr: got %h want %h", out_instr, seq[i] ^ 32'hA5A5_0000); end
    end
  endtask

  task automatic test_mid_reset();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mreset_pre: got valid %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mreset_valid: got %b want 0", out_valid); end
    n_cmp++; if (iaddr !== 32'h4) begin n_bad++; $display("FAIL mreset_iaddr: got %h want %h", iaddr, 32'h4); end
    n_cmp++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_bad++; $display("FAIL mreset_head: got pc=%h instr=%h want 0/0", out_pc, out_instr); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mreset_latency: got valid %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_bad++; $display("FAIL mreset_restart: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, 32'h4); end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    exp_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
